regfile_mp: RTL and testbench



---
 rtl/rf_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 72 +++++++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and index type.
// Used by the register file, decoder and issue logic.
package rf_pkg;

  localparam int RF_REG_COUNT  = 32;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int ZERO_IDX      = 0;

  typedef logic [RF_ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per register, set by allocate, cleared by
// write or flush. Ports: we/wr_addr, alloc, flush in; rd_addr in, rd_busy out.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int REG_COUNT  = RF_REG_COUNT,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_WRITE-1:0]          we,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  input  logic                          alloc_en,
  input  logic [ADDR_WIDTH-1:0]         alloc_addr,
  input  logic                          flush,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ-1:0]           rd_busy
);

  localparam logic [ADDR_WIDTH-1:0] ZIDX = ADDR_WIDTH'(ZERO_IDX);

  logic [REG_COUNT-1:0] busy;
  logic                 alloc_ok;

  // Flush beats allocate; reset suppresses allocate.
  assign alloc_ok = rst_n & alloc_en & ~flush
                  & ~(ZERO_REG && alloc_addr == ZIDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        automatic logic clr = 1'b0;
        for (int w = 0; w < NUM_WRITE; w++)
          if (we[w] &&
              wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i))
            clr = 1'b1;
        // A new producer supersedes the completing one.
        if (alloc_ok && alloc_addr == ADDR_WIDTH'(i))
          busy[i] <= 1'b1;
        else if (clr)
          busy[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      automatic logic [ADDR_WIDTH-1:0] idx;
      automatic logic hit = 1'b0;
      idx = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      for (int w = 0; w < NUM_WRITE; w++)
        if (we[w] && wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == idx)
          hit = 1'b1;
      if (ZERO_REG && idx == ZIDX)
        rd_busy[p] = 1'b0;
      else if (BYPASS && hit)
        rd_busy[p] = alloc_ok && alloc_addr == idx;
      else
        rd_busy[p] = busy[idx];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and busy scoreboard.
// Ports: rd_addr/rd_data/rd_busy reads, wr_* writes, alloc_*, flush.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int REG_COUNT  = RF_REG_COUNT,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ-1:0]             rd_busy,
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
  input  logic                            alloc_en,
  input  logic [ADDR_WIDTH-1:0]           alloc_addr,
  input  logic                            flush
);

  localparam logic [ADDR_WIDTH-1:0] ZIDX = ADDR_WIDTH'(ZERO_IDX);

  logic [DATA_WIDTH-1:0] mem [REG_COUNT];
  logic [NUM_WRITE-1:0]  we;

  // Qualified write strobes: no writes in reset or to the zero register.
  always_comb begin
    we = '0;
    for (int w = 0; w < NUM_WRITE; w++)
      we[w] = rst_n & wr_en[w]
            & ~(ZERO_REG && wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ZIDX);
  end

  // Later ports overwrite earlier ones, so the highest port wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++)
        mem[i] <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE; w++)
        if (we[w])
          mem[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <=
            wr_data[w*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      automatic logic [ADDR_WIDTH-1:0] idx;
      automatic logic [DATA_WIDTH-1:0] d;
      idx = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      d = mem[idx];
      if (BYPASS)
        for (int w = 0; w < NUM_WRITE; w++)
          if (we[w] && wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == idx)
            d = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
      if (ZERO_REG && idx == ZIDX)
        d = '0;
      rd_data[p*DATA_WIDTH +: DATA_WIDTH] = d;
    end
  end

  regfile_scoreboard #(
    .REG_COUNT  (REG_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .NUM_WRITE  (NUM_WRITE),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed table, reset sequence and random
// traffic against a reference model; bypassing and non-bypassing instances.
module tb_regfile_mp;
  import rf_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data, nb_data;
  logic [NR-1:0]   rd_busy, nb_busy;
  logic [NW-1:0]   wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic            flush;

  always #5 clk = ~clk;

  regfile_mp #(
    .NUM_READ(NR), .NUM_WRITE(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
  );

  regfile_mp #(
    .NUM_READ(NR), .NUM_WRITE(1), .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) u_nb (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(nb_data), .rd_busy(nb_busy),
    .wr_en(wr_en[0:0]), .wr_addr(wr_addr[AW-1:0]),
    .wr_data(wr_data[DW-1:0]),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] m_mem [32];
  logic        m_busy [32];
  logic [31:0] n_mem [32];
  logic        n_busy [32];

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        al;
    logic [4:0]  aa;
    logic        fl;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0; m_busy[i] = 1'b0;
      n_mem[i] = '0; n_busy[i] = 1'b0;
    end
  endtask

  // Expected main-instance read for index a given current inputs.
  task automatic exp_main(input int a, output logic [31:0] d,
                          output logic b);
    automatic bit hit = 0;
    d = m_mem[a];
    b = m_busy[a];
    for (int w = 0; w < NW; w++)
      if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) begin
        hit = 1;
        d = wr_data[w*DW +: DW];
      end
    if (hit) b = alloc_en && int'(alloc_addr) == a && !flush;
    if (a == 0) begin d = '0; b = 1'b0; end
  endtask

  task automatic check_model(input string tag);
    for (int p = 0; p < NR; p++) begin
      automatic int a = int'(rd_addr[p*AW +: AW]);
      automatic logic [31:0] d;
      automatic logic b;
      exp_main(a, d, b);
      chk($sformatf("%s byp data p%0d x%0d", tag, p, a),
          rd_data[p*DW +: DW], d);
      chk($sformatf("%s byp busy p%0d x%0d", tag, p, a),
          32'(rd_busy[p]), 32'(b));
      chk($sformatf("%s nob data p%0d x%0d", tag, p, a),
          nb_data[p*DW +: DW], a == 0 ? 32'h0 : n_mem[a]);
      chk($sformatf("%s nob busy p%0d x%0d", tag, p, a),
          32'(nb_busy[p]), a == 0 ? 32'h0 : 32'(n_busy[a]));
    end
  endtask

  // Apply the clock edge to the model from spec rules.
  task automatic model_edge();
    for (int w = 0; w < NW; w++) begin
      automatic int a = int'(wr_addr[w*AW +: AW]);
      if (wr_en[w] && a != 0) begin
        m_mem[a] = wr_data[w*DW +: DW];
        m_busy[a] = 1'b0;
        if (w == 0) begin
          n_mem[a] = wr_data[DW-1:0];
          n_busy[a] = 1'b0;
        end
      end
    end
    if (alloc_en && alloc_addr != 0) begin
      m_busy[alloc_addr] = 1'b1;
      n_busy[alloc_addr] = 1'b1;
    end
    if (flush)
      for (int i = 0; i < 32; i++) begin
        m_busy[i] = 1'b0;
        n_busy[i] = 1'b0;
      end
  endtask

  // Inputs are set at a negedge; check mid-cycle, then take the edge.
  task automatic cycle(input string tag);
    #2;
    check_model(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{2'b01, 5'd7, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd7, 5'd0, 32'h1234, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd7, 5'd0, 32'h1234, 32'h0, 1'b0, 1'b0};
    tbl[2]  = '{2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd0, 5'd7, 32'h0, 32'h1234, 1'b0, 1'b0};
    tbl[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[4]  = '{2'b01, 5'd3, 32'hA5A5, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd3, 5'd3, 32'hA5A5, 32'hA5A5, 1'b0, 1'b0};
    tbl[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0,
                5'd9, 5'd3, 32'h0, 32'hA5A5, 1'b0, 1'b0};
    tbl[6]  = '{2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0,
                5'd9, 5'd9, 32'h99, 32'h99, 1'b1, 1'b1};
    tbl[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd9, 5'd0, 32'h99, 32'h0, 1'b1, 1'b0};
    tbl[8]  = '{2'b01, 5'd9, 32'h77, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd9, 5'd9, 32'h77, 32'h77, 1'b0, 1'b0};
    tbl[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd9, 5'd9, 32'h77, 32'h77, 1'b0, 1'b0};
    tbl[10] = '{2'b11, 5'd4, 32'h11, 5'd4, 32'h22, 1'b0, 5'd0, 1'b0,
                5'd4, 5'd4, 32'h22, 32'h22, 1'b0, 1'b0};
    tbl[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd4, 5'd0, 32'h22, 32'h0, 1'b0, 1'b0};
    tbl[12] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0,
                5'd1, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[13] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0,
                5'd1, 5'd2, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[14] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0,
                5'd1, 5'd2, 32'h0, 32'h0, 1'b1, 1'b1};
    tbl[15] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b1,
                5'd3, 5'd8, 32'hA5A5, 32'h0, 1'b1, 1'b0};
    tbl[16] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd1, 5'd8, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[17] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd2, 5'd3, 32'h0, 32'hA5A5, 1'b0, 1'b0};
    tbl[18] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0,
                5'd0, 5'd9, 32'h0, 32'h77, 1'b0, 1'b0};
    tbl[19] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd0, 5'd9, 32'h0, 32'h77, 1'b0, 1'b0};

    // Reset state.
    rst_n = 1'b0;
    idle();
    rd_addr = {5'd5, 5'd7};
    model_clear();
    #1;
    chk("reset data", rd_data, '0);
    chk("reset busy", 32'(rd_busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 20; i++) begin
      wr_en = tbl[i].we;
      wr_addr = {tbl[i].wa1, tbl[i].wa0};
      wr_data = {tbl[i].wd1, tbl[i].wd0};
      alloc_en = tbl[i].al;
      alloc_addr = tbl[i].aa;
      flush = tbl[i].fl;
      rd_addr = {tbl[i].r1, tbl[i].r0};
      #1;
      chk($sformatf("tbl%0d d0", i), rd_data[DW-1:0], tbl[i].d0);
      chk($sformatf("tbl%0d d1", i), rd_data[2*DW-1:DW], tbl[i].d1);
      chk($sformatf("tbl%0d b0", i), 32'(rd_busy[0]), 32'(tbl[i].b0));
      chk($sformatf("tbl%0d b1", i), 32'(rd_busy[1]), 32'(tbl[i].b1));
      cycle($sformatf("tbl%0d", i));
    end

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      wr_en = 2'($urandom);
      wr_addr = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      wr_data = {$urandom, $urandom};
      alloc_en = ($urandom_range(0, 2) == 0);
      alloc_addr = 5'($urandom_range(0, 15));
      flush = ($urandom_range(0, 15) == 0);
      rd_addr = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      cycle("rnd");
    end

    // Mid-cycle asynchronous reset.
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    alloc_en = 1'b1; alloc_addr = 5'd6;
    rd_addr = {5'd6, 5'd5};
    cycle("pre-rst");
    idle();
    #2;
    chk("pre-rst x5", rd_data[DW-1:0], 32'hDEADBEEF);
    chk("pre-rst x6 busy", 32'(rd_busy[1]), 32'h1);
    #1;
    rst_n = 1'b0;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h1};
    #1;
    chk("rst x5 data", rd_data[DW-1:0], 32'h0);
    chk("rst busy", 32'(rd_busy), 32'h0);
    chk("rst nb data", nb_data[DW-1:0], 32'h0);
    chk("rst nb busy", 32'(nb_busy), 32'h0);
    @(posedge clk);
    #1;
    chk("rst held x5", rd_data[DW-1:0], 32'h0);
    chk("rst held busy", 32'(rd_busy), 32'h0);
    @(negedge clk);
    model_clear();
    idle();
    rst_n = 1'b1;

    // First edge after reset accepts a write.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hCAFE};
    rd_addr = {5'd6, 5'd5};
    cycle("post-rst w");
    idle();
    cycle("post-rst r");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
